// File: rtl/float_mult_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : float_mult_arbiter
//  Purpose  : Shares one combinational floating-point multiplier among
//             NUM_REQ requesters. A round-robin arbiter picks one request,
//             a three-state FSM (IDLE / CALC / RESP) registers the operands,
//             lets the multiplier settle for one cycle, then holds the
//             tagged product on a valid/ready response channel.
//  Ports    : clk, rst_n           clock, synchronous active-low reset
//             i_req_valid/a/b      per-requester operands (packed by index)
//             o_req_ready          one-hot accept strobe (combinational)
//             o_resp_valid/ready   response handshake
//             o_resp_out/id/flags  product, requester index, {ovf,unf,inx}
//             o_busy               FSM not idle
//             i_sticky_clr         clears accumulated flags
//             o_sticky_flags       accumulated {ovf,unf,inx}
//  Config   : define FMUL_ARB_STICKY_EN to enable the sticky flag register;
//             otherwise o_sticky_flags is 0 and i_sticky_clr is ignored.
//  Datapath : normalized inputs only, mantissa truncated (round toward
//             zero), exponent not saturated; flags report what happened.
//  Revision : 1.0  initial release
// ============================================================================
module float_mult_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int FLOAT_SIZE    = 32,
  parameter int EXPONENT_SIZE = 8,
  parameter int MANTISSA_SIZE = 23,
  parameter int BIAS          = 127,
  localparam int ID_W         = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [NUM_REQ*FLOAT_SIZE-1:0] i_req_a,
  input  logic [NUM_REQ*FLOAT_SIZE-1:0] i_req_b,
  output logic [NUM_REQ-1:0]            o_req_ready,
  output logic                          o_resp_valid,
  input  logic                          i_resp_ready,
  output logic [FLOAT_SIZE-1:0]         o_resp_out,
  output logic [ID_W-1:0]               o_resp_id,
  output logic [2:0]                    o_resp_flags,
  output logic                          o_busy,
  input  logic                          i_sticky_clr,
  output logic [2:0]                    o_sticky_flags
);

  localparam int c_MW = MANTISSA_SIZE + 1;   // mantissa with hidden one
  localparam int c_PW = 2 * c_MW;            // full mantissa product
  localparam int c_EW = EXPONENT_SIZE + 2;   // room for carry and sign

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic                  w_accept;
  logic                  w_any;
  logic [ID_W-1:0]       w_gnt_id;
  logic [ID_W-1:0]       w_idx;

  logic [FLOAT_SIZE-1:0] r_op_a;
  logic [FLOAT_SIZE-1:0] r_op_b;
  logic [ID_W-1:0]       r_id;
  logic [ID_W-1:0]       r_last_grant;
  logic [FLOAT_SIZE-1:0] r_resp_out;
  logic [ID_W-1:0]       r_resp_id;
  logic [2:0]            r_resp_flags;

  // --------------------------------------------------------------------------
  // Multiplier datapath, fed from the operand registers
  // --------------------------------------------------------------------------
  logic [c_MW-1:0]          w_ma;
  logic [c_MW-1:0]          w_mb;
  logic [c_PW-1:0]          w_prod;
  logic                     w_norm;
  logic [MANTISSA_SIZE-1:0] w_frac;
  logic                     w_inexact;
  logic [c_EW-1:0]          w_exp;
  logic                     w_ovf;
  logic                     w_unf;
  logic [FLOAT_SIZE-1:0]    w_mul_out;
  logic [2:0]               w_mul_flags;

  assign w_ma   = {1'b1, r_op_a[MANTISSA_SIZE-1:0]};
  assign w_mb   = {1'b1, r_op_b[MANTISSA_SIZE-1:0]};
  assign w_prod = {{c_MW{1'b0}}, w_ma} * {{c_MW{1'b0}}, w_mb};

  // Product of two [1,2) mantissas lies in [1,4); top bit set means [2,4).
  assign w_norm    = w_prod[c_PW-1];
  assign w_frac    = w_norm ? w_prod[c_PW-2 -: MANTISSA_SIZE]
                            : w_prod[c_PW-3 -: MANTISSA_SIZE];
  assign w_inexact = w_norm ? (|w_prod[MANTISSA_SIZE:0])
                            : (|w_prod[MANTISSA_SIZE-1:0]);

  // Two's-complement exponent; the MSB flags a negative (underflowed) value.
  assign w_exp = {2'b00, r_op_a[FLOAT_SIZE-2 -: EXPONENT_SIZE]}
               + {2'b00, r_op_b[FLOAT_SIZE-2 -: EXPONENT_SIZE]}
               + {{(c_EW-1){1'b0}}, w_norm}
               - c_EW'(BIAS);

  assign w_unf = w_exp[c_EW-1] | (w_exp == '0);
  assign w_ovf = ~w_exp[c_EW-1] & (w_exp >= c_EW'((1 << EXPONENT_SIZE) - 1));

  assign w_mul_out   = {r_op_a[FLOAT_SIZE-1] ^ r_op_b[FLOAT_SIZE-1],
                        w_exp[EXPONENT_SIZE-1:0], w_frac};
  assign w_mul_flags = {w_ovf, w_unf, w_inexact};

  // --------------------------------------------------------------------------
  // Round-robin pick: first valid requester after the last one granted
  // --------------------------------------------------------------------------
  always_comb begin
    w_gnt_id = r_last_grant;
    w_idx    = '0;
    w_any    = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = ID_W'((int'(r_last_grant) + k) % NUM_REQ);
      if (!w_any && i_req_valid[w_idx]) begin
        w_any    = 1'b1;
        w_gnt_id = w_idx;
      end
    end
  end

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_accept     = 1'b1;
          w_state_next = S_CALC;
        end
      end
      S_CALC: begin
        w_state_next = S_RESP;
      end
      S_RESP: begin
        if (i_resp_ready) begin
          if (w_any) begin
            w_accept     = 1'b1;
            w_state_next = S_CALC;
          end else begin
            w_state_next = S_IDLE;
          end
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
    // A grant during reset would be lost, so the requester must not see it.
    if (!rst_n) begin
      w_accept = 1'b0;
    end
  end

  always_comb begin
    o_req_ready = '0;
    if (w_accept) begin
      o_req_ready[w_gnt_id] = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Operand capture and response registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_id         <= '0;
      r_last_grant <= ID_W'(NUM_REQ - 1);  // requester 0 scanned first
      r_resp_out   <= '0;
      r_resp_id    <= '0;
      r_resp_flags <= '0;
    end else begin
      if (w_accept) begin
        r_op_a       <= i_req_a[w_gnt_id*FLOAT_SIZE +: FLOAT_SIZE];
        r_op_b       <= i_req_b[w_gnt_id*FLOAT_SIZE +: FLOAT_SIZE];
        r_id         <= w_gnt_id;
        r_last_grant <= w_gnt_id;
      end
      if (r_state == S_CALC) begin
        r_resp_out   <= w_mul_out;
        r_resp_flags <= w_mul_flags;
        r_resp_id    <= r_id;
      end
    end
  end

`ifdef FMUL_ARB_STICKY_EN
  logic [2:0] r_sticky;

  // A clear coinciding with completion keeps only the new flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sticky <= '0;
    end else if (r_state == S_CALC) begin
      r_sticky <= i_sticky_clr ? w_mul_flags : (r_sticky | w_mul_flags);
    end else if (i_sticky_clr) begin
      r_sticky <= '0;
    end
  end

  assign o_sticky_flags = r_sticky;
`else
  logic w_unused_sticky_clr;

  assign w_unused_sticky_clr = i_sticky_clr;
  assign o_sticky_flags      = 3'b000;
`endif

  assign o_resp_valid = (r_state == S_RESP);
  assign o_resp_out   = r_resp_out;
  assign o_resp_id    = r_resp_id;
  assign o_resp_flags = r_resp_flags;
  assign o_busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire
